// File: rtl/dll_code_ctrl.sv
// dll_code_ctrl: delay-code controller for the FMDLL loop.
// Resolves the delay-line code by successive approximation, then tracks
// it with +/-1 steps and raises Lock once the step direction has
// alternated LOCK_CNT times in a row. Also re-arms the phase detector
// through Reset_PD after every accepted comparison window.
//
// Handshake: Update is a single-cycle strobe with COMP valid in the same
// cycle; there is no back-pressure. An Update is accepted only when
// Enable=1 and the controller is in SAR or TRACK. All outputs are
// registered and change on the edge that accepts the Update.
module dll_code_ctrl #(
    parameter int CODE_W   = 6,
    parameter int LOCK_CNT = 4
) (
    input  logic              clk_out,
    input  logic              Reset_DC,
    input  logic              Enable,
    input  logic              Update,
    input  logic              COMP,
    output logic [CODE_W-1:0] Delay_code,
    output logic              Lock,
    output logic              SAR_done,
    output logic              Reset_PD,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SAR   = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int CNT_W = $clog2(LOCK_CNT + 1);
    localparam logic [CODE_W-1:0] MID     = CODE_W'(1) << (CODE_W - 1);
    localparam logic [CODE_W-1:0] MAX     = {CODE_W{1'b1}};
    localparam logic [IDX_W-1:0]  TOP_IDX = IDX_W'(CODE_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(LOCK_CNT);

    state_t            state;
    logic [CODE_W-1:0] code;
    logic [IDX_W-1:0]  bit_idx;
    logic [CNT_W-1:0]  alt_cnt;
    logic              prev_dir;   // 1 = last TRACK step was a decrement
    logic              have_prev;  // a TRACK step has already been taken
    logic              lock_q;
    logic              done_q;
    logic              pd_q;

    logic [CODE_W-1:0] sar_next;
    logic [CODE_W-1:0] track_next;
    logic [CNT_W-1:0]  cnt_next;

    // Next-value helpers for the SAR bit trial, the saturating track step
    // and the alternation counter.
    always_comb begin
        sar_next = code;
        if (COMP) begin
            sar_next[bit_idx] = 1'b0;
        end
        if (bit_idx != '0) begin
            sar_next[bit_idx - IDX_W'(1)] = 1'b1;
        end

        track_next = code;
        if (COMP) begin
            if (code != '0) begin
                track_next = code - CODE_W'(1);
            end
        end else begin
            if (code != MAX) begin
                track_next = code + CODE_W'(1);
            end
        end

        cnt_next = '0;
        if (have_prev && (COMP != prev_dir)) begin
            cnt_next = (alt_cnt == CNT_MAX) ? alt_cnt : alt_cnt + CNT_W'(1);
        end
    end

    // Main controller FSM with all outputs registered.
    always_ff @(posedge clk_out) begin
        if (!Reset_DC || !Enable) begin
            state     <= ST_IDLE;
            code      <= MID;
            bit_idx   <= TOP_IDX;
            alt_cnt   <= '0;
            prev_dir  <= 1'b0;
            have_prev <= 1'b0;
            lock_q    <= 1'b0;
            done_q    <= 1'b0;
            pd_q      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    // An Update in this cycle is deliberately ignored.
                    state     <= ST_SAR;
                    code      <= MID;
                    bit_idx   <= TOP_IDX;
                    alt_cnt   <= '0;
                    have_prev <= 1'b0;
                    lock_q    <= 1'b0;
                    done_q    <= 1'b0;
                    pd_q      <= 1'b0;
                end
                ST_SAR: begin
                    pd_q <= Update;
                    if (Update) begin
                        code <= sar_next;
                        if (bit_idx == '0) begin
                            state  <= ST_TRACK;
                            done_q <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx - IDX_W'(1);
                        end
                    end
                end
                ST_TRACK: begin
                    pd_q <= Update;
                    if (Update) begin
                        code      <= track_next;
                        alt_cnt   <= cnt_next;
                        lock_q    <= (cnt_next == CNT_MAX);
                        prev_dir  <= COMP;
                        have_prev <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    code  <= MID;
                    pd_q  <= 1'b1;
                end
            endcase
        end
    end

    assign Delay_code = code;
    assign Lock       = lock_q;
    assign SAR_done   = done_q;
    assign Reset_PD   = pd_q;
    assign state_dbg  = state;

endmodule

// File: tb/tb_dll_code_ctrl.sv
// tb_dll_code_ctrl: bench for dll_code_ctrl (CODE_W=6, LOCK_CNT=4).
// Vector table for the documented scenarios, hand sequences for
// saturation and mid-operation reset, then random stimulus against a
// behavioural model.
module tb_dll_code_ctrl;

    localparam int CODE_W   = 6;
    localparam int LOCK_CNT = 4;
    localparam int MID      = 1 << (CODE_W - 1);
    localparam int MAXC     = (1 << CODE_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk_out = 1'b0;
    always #5 clk_out = ~clk_out;

    logic              Reset_DC = 1'b0;
    logic              Enable   = 1'b0;
    logic              Update   = 1'b0;
    logic              COMP     = 1'b0;
    logic [CODE_W-1:0] Delay_code;
    logic              Lock;
    logic              SAR_done;
    logic              Reset_PD;
    logic [1:0]        state_dbg;

    dll_code_ctrl #(.CODE_W(CODE_W), .LOCK_CNT(LOCK_CNT)) dut (
        .clk_out    (clk_out),
        .Reset_DC   (Reset_DC),
        .Enable     (Enable),
        .Update     (Update),
        .COMP       (COMP),
        .Delay_code (Delay_code),
        .Lock       (Lock),
        .SAR_done   (SAR_done),
        .Reset_PD   (Reset_PD),
        .state_dbg  (state_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 searching, 2 tracking
    int   m_mode = 0;
    int   m_code = MID;
    int   m_step = MID;
    bit   m_hist[$];
    bit   m_lock = 0;
    bit   m_done = 0;
    bit   m_pd   = 1;

    function automatic int trailing_alternations();
        int n = 0;
        for (int j = m_hist.size() - 1; j > 0; j--) begin
            if (m_hist[j] != m_hist[j-1]) n++;
            else break;
        end
        return n;
    endfunction

    task automatic model_step(input bit r, input bit e, input bit u, input bit c);
        if (!r || !e) begin
            m_mode = 0; m_code = MID; m_step = MID;
            m_hist.delete(); m_lock = 0; m_done = 0; m_pd = 1;
        end else if (m_mode == 0) begin
            m_mode = 1; m_code = MID; m_step = MID;
            m_hist.delete(); m_lock = 0; m_done = 0; m_pd = 0;
        end else begin
            m_pd = u;
            if (u && m_mode == 1) begin
                if (c) m_code = m_code - m_step;
                if (m_step > 1) begin
                    m_code = m_code + m_step / 2;
                    m_step = m_step / 2;
                end else begin
                    m_mode = 2;
                    m_done = 1;
                end
            end else if (u && m_mode == 2) begin
                if (c) m_code = (m_code > 0) ? m_code - 1 : 0;
                else   m_code = (m_code < MAXC) ? m_code + 1 : MAXC;
                m_hist.push_back(c);
                if (m_hist.size() > 16) void'(m_hist.pop_front());
                m_lock = (trailing_alternations() >= LOCK_CNT);
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [8:0] exp_q[$];

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got code=%0d lock=%b done=%b pd=%b, expected code=%0d lock=%b done=%b pd=%b",
                     name, got[8:3], got[2], got[1], got[0],
                     want[8:3], want[2], want[1], want[0]);
        end
    endtask

    function automatic logic [8:0] dut_out();
        return {Delay_code, Lock, SAR_done, Reset_PD};
    endfunction

    // ---------------- driver ----------------
    // Entered and left at a negedge; inputs are sampled at the posedge,
    // outputs compared to the model at the following negedge.
    task automatic cycle(input bit r, input bit e, input bit u, input bit c);
        logic [8:0] want;
        Reset_DC = r; Enable = e; Update = u; COMP = c;
        @(posedge clk_out);
        model_step(r, e, u, c);
        exp_q.push_back({6'(m_code), m_lock, m_done, m_pd});
        @(negedge clk_out);
        want = exp_q.pop_front();
        check("model", dut_out(), want);
    endtask

    task automatic expect_now(input string name, input int code, input bit l,
                              input bit d, input bit p);
        check(name, dut_out(), {6'(code), l, d, p});
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit r; bit e; bit u; bit c;
        int code; bit l; bit d; bit p;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input bit r, input bit e, input bit u, input bit c,
                       input int code, input bit l, input bit d, input bit p);
        vec_t v;
        v.r = r; v.e = e; v.u = u; v.c = c;
        v.code = code; v.l = l; v.d = d; v.p = p;
        vecs.push_back(v);
    endtask

    initial begin
        bit last_c;
        @(negedge clk_out);

        // reset values: 3 cycles in reset, then released with Enable=0
        add(0,0,0,0, 32,0,0,1); add(0,0,0,0, 32,0,0,1); add(0,0,0,0, 32,0,0,1);
        add(1,0,0,0, 32,0,0,1);
        // entering SAR: the coincident Update is ignored
        add(1,1,1,1, 32,0,0,0);
        // SAR resolve, COMP = 1,0,1,1,0,0
        add(1,1,1,1, 16,0,0,1); add(1,1,0,0, 16,0,0,0);
        add(1,1,1,0, 24,0,0,1); add(1,1,0,0, 24,0,0,0);
        add(1,1,1,1, 20,0,0,1); add(1,1,0,0, 20,0,0,0);
        add(1,1,1,1, 18,0,0,1); add(1,1,0,0, 18,0,0,0);
        add(1,1,1,0, 19,0,0,1); add(1,1,0,0, 19,0,0,0);
        add(1,1,1,0, 19,0,1,1); add(1,1,0,0, 19,0,1,0);
        // track and lock, COMP = 1,0,1,0,1 then 1
        add(1,1,1,1, 18,0,1,1); add(1,1,0,0, 18,0,1,0);
        add(1,1,1,0, 19,0,1,1); add(1,1,0,0, 19,0,1,0);
        add(1,1,1,1, 18,0,1,1); add(1,1,0,0, 18,0,1,0);
        add(1,1,1,0, 19,0,1,1); add(1,1,0,0, 19,0,1,0);
        add(1,1,1,1, 18,1,1,1); add(1,1,0,0, 18,1,1,0);
        add(1,1,1,1, 17,0,1,1); add(1,1,0,0, 17,0,1,0);
        // back-to-back updates re-acquire lock; Reset_PD stays high
        add(1,1,1,0, 18,0,1,1); add(1,1,1,1, 17,0,1,1);
        add(1,1,1,0, 18,0,1,1); add(1,1,1,1, 17,1,1,1);
        // Enable drop with a coincident Update: update discarded
        add(1,0,1,0, 32,0,0,1); add(1,0,0,0, 32,0,0,1);

        foreach (vecs[k]) begin
            cycle(vecs[k].r, vecs[k].e, vecs[k].u, vecs[k].c);
            check($sformatf("vec%0d", k), dut_out(),
                  {6'(vecs[k].code), vecs[k].l, vecs[k].d, vecs[k].p});
        end

        // saturation high: all COMP=0 resolves to 63, further steps stay there
        cycle(1,1,0,0);
        for (int k = 0; k < 6; k++) cycle(1,1,1,0);
        expect_now("sar_all0", 63, 0, 1, 1);
        for (int k = 0; k < 3; k++) cycle(1,1,1,0);
        expect_now("track_sat63", 63, 0, 1, 1);

        // saturation low: all COMP=1 resolves to 0, further steps stay there
        cycle(1,0,0,0);
        cycle(1,1,0,0);
        for (int k = 0; k < 6; k++) cycle(1,1,1,1);
        expect_now("sar_all1", 0, 0, 1, 1);
        for (int k = 0; k < 2; k++) cycle(1,1,1,1);
        expect_now("track_sat0", 0, 0, 1, 1);

        // reset after the third SAR update, then a full six-update rerun
        cycle(1,0,0,0);
        cycle(1,1,0,0);
        cycle(1,1,1,1); cycle(1,1,1,0); cycle(1,1,1,1);
        cycle(0,1,0,0);
        expect_now("mid_reset", 32, 0, 0, 1);
        cycle(1,1,0,0);
        expect_now("sar_reenter", 32, 0, 0, 0);
        for (int k = 0; k < 5; k++) cycle(1,1,1,0);
        expect_now("sar_five_not_done", 63, 0, 0, 1);
        cycle(1,1,1,1);
        expect_now("sar_six_done", 62, 0, 1, 1);

        // random stimulus against the model
        last_c = 0;
        for (int k = 0; k < 3000; k++) begin
            bit r, e, u, c;
            r = ($urandom_range(0, 299) != 0);
            e = ($urandom_range(0, 59) != 0);
            u = ($urandom_range(0, 1) == 1);
            if (k % 600 < 300) c = ($urandom_range(0, 1) == 1);
            else               c = ($urandom_range(0, 5) == 0) ? last_c : ~last_c;
            if (u) last_c = c;
            cycle(r, e, u, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
